branch_resolve_unit: RTL and testbench
======================================

// Module: branch_resolve_unit
// PURPOSE
// Consumer end of the ALU result/flag interface: holds the N/Z/C flag register written by
// flag-setting ALU ops and resolves B, CBZ, CBNZ and B.cond requests from decode.
// CBZ/CBNZ operands are passed through the ALU (select 4'b0111, pass dataB); this unit uses that op's Z.
// Emits a registered one-cycle redirect (taken/not-taken PC) to fetch. Sits between the execute and fetch stages.
// PARAMETERS
// n        64  datapath / PC width
// MAXPEND   4  max flag-setting ALU ops in flight (pending counter saturation point)
// PORTS
// clk           in   1  clock, all state updates on rising edge
// reset         in   1  synchronous, active-high reset
// flush         in   1  pipeline flush: drop request, clear pending count
// br_valid      in   1  branch request valid
// br_ready      out  1  unit can accept a request (high only in IDLE)
// br_kind       in   2  00 B, 01 CBZ, 10 CBNZ, 11 B.cond
// br_cond       in   4  ARM condition code (B.cond only)
// br_pc         in   n  PC of the branch instruction
// br_offset     in   n  sign-extended word offset (shifted left 2 internally)
// fs_issue      in   1  a flag-setting ALU op is issued this cycle
// fs_stall      out  1  pending count == MAXPEND; issue must hold
// alu_valid     in   1  ALU result valid this cycle
// alu_setflags  in   1  valid result belongs to a flag-setting op
// alu_result    in   n  ALU result (bit n-1 -> N flag)
// alu_z, alu_c  in   1  ALU zero / carry-out
// redirect_valid out 1  one-cycle pulse: branch resolved
// redirect_taken out 1  branch taken
// redirect_pc   out  n  taken ? br_pc + (br_offset<<2) : br_pc + 4 (mod 2^n)
// bad_cond      out  1  with redirect_valid: unsupported cond (needs V); forced not-taken
// flags         out  3  {N,Z,C} flag register
// BEHAVIOUR
// - Reset: state IDLE, flags=0, pend=0, redirect_valid/taken/bad_cond=0, redirect_pc=0; reset wins over all.
// - Flag write: alu_valid & alu_setflags -> flags <= {alu_result[n-1], alu_z, alu_c}.
// - pend: +1 on fs_issue (ignored while fs_stall), -1 on alu_valid&alu_setflags (ignored at 0);
//   both in same cycle -> unchanged. flush -> pend<=0, flags kept.
// - FSM: IDLE, WAIT_FLAGS, WAIT_OPND, EVAL.
//   IDLE: br_ready=1; on br_valid capture kind/cond/pc/offset; B -> EVAL;
//     B.cond -> EVAL if pend==0 else WAIT_FLAGS; CBZ/CBNZ -> WAIT_OPND.
//   WAIT_FLAGS: -> EVAL when pend==0 (flag write of last op lands same edge).
//   WAIT_OPND: on alu_valid & ~alu_setflags capture alu_z as operand-zero, -> EVAL.
//   EVAL: evaluate, register redirect outputs at this edge, -> IDLE.
// - Latency accept->redirect_valid: B / B.cond with pend==0: 2 cycles; CBZ: 1 cycle after operand capture + 1.
// - redirect_valid is high exactly one cycle; other redirect outputs hold until next resolve.
// - Conditions: EQ 0000 Z, NE 0001 !Z, HS 0010 C, LO 0011 !C, MI 0100 N, PL 0101 !N,
//   HI 1000 C&!Z, LS 1001 !C|Z, AL 1110/1111 1; 0110,0111,1010-1101 -> bad_cond=1, not taken.
// - CBZ taken iff captured Z=1; CBNZ iff Z=0. B always taken.
// - flush in any state -> IDLE next edge, no redirect issued; flush in EVAL suppresses redirect.
// - Arithmetic: PC adds are n-bit, wrap silently; offset shift drops top 2 bits.
// STRUCTURE
// - branch_defs.vh: br_kind encodings, condition code constants, ALU select 4'b0111 (PASS_B).
// - Sub-module cond_eval (combinational): {N,Z,C}, cond -> taken, bad.
// TESTING
// - B, pc=0x1000, offset=0x10 -> 2 cycles later redirect_valid=1, taken=1, pc=0x1040.
// - fs_issue, B.cond EQ; 3 cycles later alu_valid&setflags, alu_z=1 -> resolve after write, taken=1.
// - CBNZ pc=0x2000, then alu_valid, alu_z=0 -> taken, redirect_pc=0x2000+(off<<2); alu_z=1 -> pc=0x2004.
// - B.cond 1010 (GE) -> redirect_valid=1, bad_cond=1, taken=0, redirect_pc=br_pc+4.
// - 4x fs_issue -> fs_stall=1; simultaneous fs_issue+flag write -> pend stays 4.
// - pc=0xFFFF_FFFF_FFFF_FFFC, B offset=1 -> redirect_pc=0; flush during WAIT_OPND -> no redirect, br_ready=1.

Source files
------------

// File: rtl/branch_resolve_unit_pkg.sv
// Shared encodings for the branch resolve unit: branch kinds, FSM states and
// ARM condition codes.
package branch_resolve_unit_pkg;

  typedef enum logic [1:0] {
    BK_B     = 2'b00,
    BK_CBZ   = 2'b01,
    BK_CBNZ  = 2'b10,
    BK_BCOND = 2'b11
  } br_kind_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT_FLAGS,
    ST_WAIT_OPND,
    ST_EVAL
  } state_e;

  localparam logic [3:0] CC_EQ = 4'b0000;
  localparam logic [3:0] CC_NE = 4'b0001;
  localparam logic [3:0] CC_HS = 4'b0010;
  localparam logic [3:0] CC_LO = 4'b0011;
  localparam logic [3:0] CC_MI = 4'b0100;
  localparam logic [3:0] CC_PL = 4'b0101;
  localparam logic [3:0] CC_HI = 4'b1000;
  localparam logic [3:0] CC_LS = 4'b1001;
  localparam logic [3:0] CC_AL = 4'b1110;
  localparam logic [3:0] CC_NV = 4'b1111;

endpackage

// File: rtl/branch_resolve_unit_cond_eval.sv
// Combinational ARM condition evaluator over the {N,Z,C} flags; codes that
// need the V flag are reported as bad and evaluate not-taken.
module cond_eval
  import branch_resolve_unit_pkg::*;
(
  input  logic [2:0] nzc,
  input  logic [3:0] cond,
  output logic       taken,
  output logic       bad
);

  logic n, z, c;
  assign {n, z, c} = nzc;

  always_comb begin
    taken = 1'b0;
    bad   = 1'b0;
    case (cond)
      CC_EQ:        taken = z;
      CC_NE:        taken = ~z;
      CC_HS:        taken = c;
      CC_LO:        taken = ~c;
      CC_MI:        taken = n;
      CC_PL:        taken = ~n;
      CC_HI:        taken = c & ~z;
      CC_LS:        taken = ~c | z;
      CC_AL, CC_NV: taken = 1'b1;
      default:      bad   = 1'b1;
    endcase
  end

endmodule

// File: rtl/branch_resolve_unit.sv
// Branch resolve unit: owns the N/Z/C flag register and the in-flight
// flag-setter count, resolves B/CBZ/CBNZ/B.cond and pulses a redirect to fetch.
module branch_resolve_unit
  import branch_resolve_unit_pkg::*;
#(
  parameter int n       = 64,
  parameter int MAXPEND = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         flush,
  input  logic         br_valid,
  output logic         br_ready,
  input  logic [1:0]   br_kind,
  input  logic [3:0]   br_cond,
  input  logic [n-1:0] br_pc,
  input  logic [n-1:0] br_offset,
  input  logic         fs_issue,
  output logic         fs_stall,
  input  logic         alu_valid,
  input  logic         alu_setflags,
  input  logic [n-1:0] alu_result,
  input  logic         alu_z,
  input  logic         alu_c,
  output logic         redirect_valid,
  output logic         redirect_taken,
  output logic [n-1:0] redirect_pc,
  output logic         bad_cond,
  output logic [2:0]   flags
);

  localparam int PW = $clog2(MAXPEND + 1);

  state_e         state;
  logic [PW-1:0]  pend;
  logic [2:0]     flags_q;
  br_kind_e       kind_q;
  logic [3:0]     cond_q;
  logic [n-1:0]   pc_q;
  logic [n-1:0]   off_q;
  logic           opz_q;

  logic           fs_write;
  logic           opnd_hit;
  logic           cc_taken;
  logic           cc_bad;
  logic           eval_taken;
  logic           eval_bad;
  logic [n-1:0]   tgt_pc;
  logic [n-1:0]   seq_pc;
  logic           unused_result_bits;

  assign fs_write = alu_valid & alu_setflags;
  assign opnd_hit = alu_valid & ~alu_setflags;
  assign fs_stall = (pend == PW'(MAXPEND));
  assign br_ready = (state == ST_IDLE);
  assign flags    = flags_q;

  // Only the sign bit of the ALU result feeds the N flag.
  assign unused_result_bits = ^alu_result[n-2:0];

  cond_eval u_cond_eval (
    .nzc   (flags_q),
    .cond  (cond_q),
    .taken (cc_taken),
    .bad   (cc_bad)
  );

  assign tgt_pc = pc_q + (off_q << 2);
  assign seq_pc = pc_q + n'(4);

  always_comb begin
    eval_taken = 1'b0;
    eval_bad   = 1'b0;
    case (kind_q)
      BK_B:     eval_taken = 1'b1;
      BK_CBZ:   eval_taken = opz_q;
      BK_CBNZ:  eval_taken = ~opz_q;
      BK_BCOND: begin
        eval_taken = cc_taken;
        eval_bad   = cc_bad;
      end
      default:  eval_taken = 1'b0;
    endcase
  end

  // Flag register and pending count; an issue and a retire in the same
  // cycle cancel even when the counter is saturated.
  always_ff @(posedge clk) begin
    if (reset) begin
      flags_q <= 3'b000;
      pend    <= '0;
    end else begin
      if (fs_write)
        flags_q <= {alu_result[n-1], alu_z, alu_c};
      if (flush)
        pend <= '0;
      else if (fs_issue && !fs_write) begin
        if (!fs_stall)
          pend <= pend + 1'b1;
      end else if (fs_write && !fs_issue && (pend != '0))
        pend <= pend - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (state == ST_IDLE && br_valid) begin
      kind_q <= br_kind_e'(br_kind);
      cond_q <= br_cond;
      pc_q   <= br_pc;
      off_q  <= br_offset;
    end
    if (state == ST_WAIT_OPND && opnd_hit)
      opz_q <= alu_z;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state          <= ST_IDLE;
      redirect_valid <= 1'b0;
      redirect_taken <= 1'b0;
      redirect_pc    <= '0;
      bad_cond       <= 1'b0;
    end else begin
      redirect_valid <= 1'b0;
      if (flush)
        state <= ST_IDLE;
      else begin
        case (state)
          ST_IDLE: begin
            if (br_valid) begin
              case (br_kind_e'(br_kind))
                BK_B:     state <= ST_EVAL;
                BK_BCOND: state <= (pend == '0) ? ST_EVAL : ST_WAIT_FLAGS;
                default:  state <= ST_WAIT_OPND;
              endcase
            end
          end
          ST_WAIT_FLAGS: if (pend == '0) state <= ST_EVAL;
          ST_WAIT_OPND:  if (opnd_hit) state <= ST_EVAL;
          ST_EVAL: begin
            redirect_valid <= 1'b1;
            redirect_taken <= eval_taken;
            bad_cond       <= eval_bad;
            redirect_pc    <= eval_taken ? tgt_pc : seq_pc;
            state          <= ST_IDLE;
          end
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Directed bench for branch_resolve_unit: hand-computed redirects, flag
// writes, pending-count saturation, PC wrap and flush behaviour.
module tb_branch_resolve_unit;

  logic        clk = 1'b0;
  logic        reset, flush, br_valid, br_ready;
  logic [1:0]  br_kind;
  logic [3:0]  br_cond;
  logic [63:0] br_pc, br_offset;
  logic        fs_issue, fs_stall;
  logic        alu_valid, alu_setflags, alu_z, alu_c;
  logic [63:0] alu_result;
  logic        redirect_valid, redirect_taken, bad_cond;
  logic [63:0] redirect_pc;
  logic [2:0]  flags;

  int checks   = 0;
  int failures = 0;

  branch_resolve_unit #(.n(64), .MAXPEND(4)) dut (
    .clk            (clk),
    .reset          (reset),
    .flush          (flush),
    .br_valid       (br_valid),
    .br_ready       (br_ready),
    .br_kind        (br_kind),
    .br_cond        (br_cond),
    .br_pc          (br_pc),
    .br_offset      (br_offset),
    .fs_issue       (fs_issue),
    .fs_stall       (fs_stall),
    .alu_valid      (alu_valid),
    .alu_setflags   (alu_setflags),
    .alu_result     (alu_result),
    .alu_z          (alu_z),
    .alu_c          (alu_c),
    .redirect_valid (redirect_valid),
    .redirect_taken (redirect_taken),
    .redirect_pc    (redirect_pc),
    .bad_cond       (bad_cond),
    .flags          (flags)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $display("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      $error("check %s", tag);
    end
  endtask

  task automatic send_br(input logic [1:0] kind, input logic [3:0] cond,
                         input logic [63:0] pc, input logic [63:0] off);
    br_valid  = 1'b1;
    br_kind   = kind;
    br_cond   = cond;
    br_pc     = pc;
    br_offset = off;
    step();
    br_valid  = 1'b0;
  endtask

  task automatic alu_op(input logic setf, input logic [63:0] res, input logic z, input logic c);
    alu_valid    = 1'b1;
    alu_setflags = setf;
    alu_result   = res;
    alu_z        = z;
    alu_c        = c;
    step();
    alu_valid    = 1'b0;
    alu_setflags = 1'b0;
  endtask

  initial begin
    reset = 1'b1; flush = 1'b0; br_valid = 1'b0; br_kind = 2'b00; br_cond = 4'h0;
    br_pc = '0; br_offset = '0; fs_issue = 1'b0; alu_valid = 1'b0; alu_setflags = 1'b0;
    alu_result = '0; alu_z = 1'b0; alu_c = 1'b0;
    step(); step();
    chk("rst_ready", 64'(br_ready), 64'd1);
    chk("rst_rv", 64'(redirect_valid), 64'd0);
    chk("rst_taken", 64'(redirect_taken), 64'd0);
    chk("rst_bad", 64'(bad_cond), 64'd0);
    chk("rst_pc", redirect_pc, 64'd0);
    chk("rst_flags", 64'(flags), 64'd0);
    chk("rst_stall", 64'(fs_stall), 64'd0);
    reset = 1'b0;
    step();

    // Unconditional branch: two-cycle latency
    send_br(2'b00, 4'h0, 64'h1000, 64'h10);
    chk("b_rv_early", 64'(redirect_valid), 64'd0);
    chk("b_busy", 64'(br_ready), 64'd0);
    step();
    chk("b_rv", 64'(redirect_valid), 64'd1);
    chk("b_taken", 64'(redirect_taken), 64'd1);
    chk("b_pc", redirect_pc, 64'h1040);
    chk("b_bad", 64'(bad_cond), 64'd0);
    step();
    chk("b_rv_pulse", 64'(redirect_valid), 64'd0);
    chk("b_pc_hold", redirect_pc, 64'h1040);

    // B.cond EQ waits for the outstanding flag-setter
    fs_issue = 1'b1; step(); fs_issue = 1'b0;
    send_br(2'b11, 4'b0000, 64'h3000, 64'h8);
    step(); step();
    chk("eq_wait_rv", 64'(redirect_valid), 64'd0);
    alu_op(1'b1, 64'h0, 1'b1, 1'b0);
    chk("eq_flags", 64'(flags), 64'b010);
    step();
    chk("eq_rv_early", 64'(redirect_valid), 64'd0);
    step();
    chk("eq_rv", 64'(redirect_valid), 64'd1);
    chk("eq_taken", 64'(redirect_taken), 64'd1);
    chk("eq_pc", redirect_pc, 64'h3020);

    // CBNZ with a nonzero operand: taken
    send_br(2'b10, 4'h0, 64'h2000, 64'h40);
    alu_op(1'b0, 64'h5, 1'b0, 1'b1);
    chk("cbnz_rv_early", 64'(redirect_valid), 64'd0);
    chk("cbnz_flags_kept", 64'(flags), 64'b010);
    step();
    chk("cbnz_rv", 64'(redirect_valid), 64'd1);
    chk("cbnz_taken", 64'(redirect_taken), 64'd1);
    chk("cbnz_pc", redirect_pc, 64'h2100);

    // CBNZ with a zero operand: falls through
    send_br(2'b10, 4'h0, 64'h2000, 64'h40);
    alu_op(1'b0, 64'h0, 1'b1, 1'b0);
    step();
    chk("cbnz0_rv", 64'(redirect_valid), 64'd1);
    chk("cbnz0_taken", 64'(redirect_taken), 64'd0);
    chk("cbnz0_pc", redirect_pc, 64'h2004);

    // CBZ with a zero operand: taken
    send_br(2'b01, 4'h0, 64'h5000, 64'h4);
    alu_op(1'b0, 64'h0, 1'b1, 1'b0);
    step();
    chk("cbz_taken", 64'(redirect_taken), 64'd1);
    chk("cbz_pc", redirect_pc, 64'h5010);

    // GE needs V: reported bad, forced not-taken
    send_br(2'b11, 4'b1010, 64'h4000, 64'h10);
    step();
    chk("ge_rv", 64'(redirect_valid), 64'd1);
    chk("ge_bad", 64'(bad_cond), 64'd1);
    chk("ge_taken", 64'(redirect_taken), 64'd0);
    chk("ge_pc", redirect_pc, 64'h4004);

    // Flags N=1 Z=0 C=1, then HI / MI / LS
    alu_op(1'b1, 64'h8000_0000_0000_0000, 1'b0, 1'b1);
    chk("nc_flags", 64'(flags), 64'b101);
    send_br(2'b11, 4'b1000, 64'h6000, 64'h4);
    step();
    chk("hi_taken", 64'(redirect_taken), 64'd1);
    chk("hi_bad", 64'(bad_cond), 64'd0);
    chk("hi_pc", redirect_pc, 64'h6010);
    send_br(2'b11, 4'b0100, 64'h6100, 64'h2);
    step();
    chk("mi_taken", 64'(redirect_taken), 64'd1);
    chk("mi_pc", redirect_pc, 64'h6108);
    send_br(2'b11, 4'b1001, 64'h6200, 64'h2);
    step();
    chk("ls_taken", 64'(redirect_taken), 64'd0);
    chk("ls_pc", redirect_pc, 64'h6204);

    // Pending counter saturation and cancel
    fs_issue = 1'b1;
    step(); step(); step();
    chk("pend3_stall", 64'(fs_stall), 64'd0);
    step();
    chk("pend4_stall", 64'(fs_stall), 64'd1);
    step();
    chk("pend_sat_stall", 64'(fs_stall), 64'd1);
    alu_op(1'b1, 64'h0, 1'b0, 1'b0);
    chk("pend_cancel_stall", 64'(fs_stall), 64'd1);
    fs_issue = 1'b0;
    alu_op(1'b1, 64'h0, 1'b0, 1'b0);
    chk("pend_dec_stall", 64'(fs_stall), 64'd0);
    fs_issue = 1'b1; step(); fs_issue = 1'b0;
    chk("pend_re4_stall", 64'(fs_stall), 64'd1);
    flush = 1'b1; step(); flush = 1'b0;
    chk("flush_stall", 64'(fs_stall), 64'd0);
    send_br(2'b11, 4'b1110, 64'h7000, 64'h3);
    step();
    chk("al_rv", 64'(redirect_valid), 64'd1);
    chk("al_pc", redirect_pc, 64'h700C);

    // PC wrap and dropped offset bits
    send_br(2'b00, 4'h0, 64'hFFFF_FFFF_FFFF_FFFC, 64'h1);
    step();
    chk("wrap_pc", redirect_pc, 64'h0);
    send_br(2'b00, 4'h0, 64'h100, 64'hC000_0000_0000_0002);
    step();
    chk("offtop_pc", redirect_pc, 64'h108);

    // Flush in WAIT_OPND: request dropped
    send_br(2'b01, 4'h0, 64'h9000, 64'h10);
    chk("wo_busy", 64'(br_ready), 64'd0);
    flush = 1'b1; step(); flush = 1'b0;
    chk("wo_flush_ready", 64'(br_ready), 64'd1);
    chk("wo_flush_rv", 64'(redirect_valid), 64'd0);
    alu_op(1'b0, 64'h0, 1'b1, 1'b0);
    step();
    chk("wo_no_rv", 64'(redirect_valid), 64'd0);
    chk("wo_pc_hold", redirect_pc, 64'h108);

    // Flush in EVAL: redirect suppressed
    send_br(2'b00, 4'h0, 64'hA000, 64'h1);
    flush = 1'b1; step(); flush = 1'b0;
    chk("ev_flush_rv", 64'(redirect_valid), 64'd0);
    chk("ev_flush_pc", redirect_pc, 64'h108);
    chk("ev_flush_ready", 64'(br_ready), 64'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
